// File: rtl/scan_mux.sv
// scan_mux: registered WIDTH-bit, CHANNELS-to-1 multiplexer with manual
// select and an automatic scan tour over the enabled channels.
//
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous, active-high reset
//   data_in  CHANNELS*WIDTH packed channels, channel 0 in the LSBs
//   sel      channel requested in manual mode (ignored if >= CHANNELS)
//   mode     0 = manual, 1 = scan
//   hold     1 = freeze selection, dwell counter and output
//   mask     bit k = 1 includes channel k in the scan tour
//   out      registered data of the selected channel
//   cur_ch   channel currently selected
//   tick     one-cycle pulse after each scan dwell expiry
module scan_mux #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 25_000_000,
  localparam int unsigned SEL_W   = $clog2(CHANNELS),
  localparam int unsigned CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
  input  logic [CHANNELS-1:0]       mask,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      tick
);

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] sel_data;
  logic [SEL_W-1:0] next_ch;
  logic             sel_ok;

  // Next enabled channel strictly after cur, wrapping; cur itself is the
  // last candidate, so a mask holding only cur keeps the selection.
  function automatic logic [SEL_W-1:0] next_enabled(
    input logic [SEL_W-1:0]    cur,
    input logic [CHANNELS-1:0] msk
  );
    logic [SEL_W-1:0] pick;
    int               best_d;
    int               d;
    pick   = cur;
    best_d = int'(CHANNELS) + 1;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (msk[k]) begin
        d = (k > int'(cur)) ? (k - int'(cur)) : (k + int'(CHANNELS) - int'(cur));
        if (d < best_d) begin
          best_d = d;
          pick   = SEL_W'(k);
        end
      end
    end
    return pick;
  endfunction

  // Data of the registered current channel.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (cur_ch_q == SEL_W'(k)) sel_data = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign next_ch = next_enabled(cur_ch_q, mask);
  assign sel_ok  = (32'(sel) < CHANNELS);

  // Next state and registered-output next values. The action for an edge
  // follows the state being entered, so hold/mode take effect on the same
  // edge they are sampled (hold on an expiry edge suppresses that expiry).
  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    tick_d   = 1'b0;

    if (hold)      state_d = ST_FROZEN;
    else if (mode) state_d = ST_SCAN;
    else           state_d = ST_MANUAL;

    case (state_d)
      ST_MANUAL: begin
        cnt_d = '0;
        out_d = sel_data;
        if (sel_ok) cur_ch_d = sel;
      end
      ST_SCAN: begin
        out_d = sel_data;
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (|mask) begin
          // Dwell expiry; with an empty mask the counter parks at CNT_LAST.
          cnt_d    = '0;
          tick_d   = 1'b1;
          cur_ch_d = next_ch;
        end
      end
      default: begin
        // Frozen: everything holds, tick stays low.
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_MANUAL;
      cur_ch_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      tick_q   <= tick_d;
    end
  end

  assign out    = out_q;
  assign cur_ch = cur_ch_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: scoreboard bench for scan_mux. Two instances share stimulus:
// a 4-channel/DWELL=3 unit and a 3-channel/DWELL=2 unit.
module tb_scan_mux;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [1:0]  sel;
  logic        mode;
  logic        hold;
  logic [3:0]  mask;

  logic [3:0]  out4;
  logic [1:0]  cur4;
  logic        tick4;
  logic [3:0]  out3;
  logic [1:0]  cur3;
  logic        tick3;

  int checks   = 0;
  int failures = 0;

  scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) u_dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .mode(mode),
    .hold(hold), .mask(mask), .out(out4), .cur_ch(cur4), .tick(tick4)
  );

  scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(2)) u_dut3 (
    .clk(clk), .rst(rst), .data_in(data_in[11:0]), .sel(sel), .mode(mode),
    .hold(hold), .mask(mask[2:0]), .out(out3), .cur_ch(cur3), .tick(tick3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       cur;
    int       cnt;
    logic [3:0] out;
    bit       tick;
  } mdl_t;

  mdl_t m4 = '{0, 0, 4'h0, 1'b0};
  mdl_t m3 = '{0, 0, 4'h0, 1'b0};
  mdl_t q4[$];
  mdl_t q3[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: one clock edge of the specified block.
  function automatic mdl_t step(mdl_t m, bit r, bit h, bit md, int s, int msk,
                                logic [15:0] din, int nch, int dw);
    mdl_t n;
    n = m;
    n.tick = 1'b0;
    if (r) begin
      n.cur = 0; n.cnt = 0; n.out = 4'h0;
      return n;
    end
    if (h) return n;
    n.out = din[m.cur*4 +: 4];
    if (!md) begin
      n.cnt = 0;
      if (s < nch) n.cur = s;
    end else if (m.cnt < dw - 1) begin
      n.cnt = m.cnt + 1;
    end else if (msk != 0) begin
      n.cnt  = 0;
      n.tick = 1'b1;
      for (int i = 1; i <= nch; i++) begin
        if (msk[(m.cur + i) % nch]) begin
          n.cur = (m.cur + i) % nch;
          break;
        end
      end
    end
    return n;
  endfunction

  // Scoreboard producer: expected post-edge outputs for each edge.
  always @(posedge clk) begin
    m4 = step(m4, rst, hold, mode, int'(sel), int'(mask), data_in, 4, 3);
    m3 = step(m3, rst, hold, mode, int'(sel), int'(mask[2:0]), {4'h0, data_in[11:0]}, 3, 2);
    q4.push_back(m4);
    q3.push_back(m3);
  end

  // Monitor: compare settled DUT outputs with the queued expectations.
  always @(negedge clk) begin
    mdl_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      check("dut4.out",    16'(out4),  16'(e.out));
      check("dut4.cur_ch", 16'(cur4),  16'(e.cur));
      check("dut4.tick",   16'(tick4), 16'(e.tick));
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      check("dut3.out",    16'(out3),  16'(e.out));
      check("dut3.cur_ch", 16'(cur3),  16'(e.cur));
      check("dut3.tick",   16'(tick3), 16'(e.tick));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] saved_out;
  logic [1:0] saved_cur;
  logic [1:0] tour [4];

  initial begin
    rst = 1'b1; mode = 1'b0; hold = 1'b0; sel = 2'd0; mask = 4'h0; data_in = 16'h0;
    cyc(2);
    check("reset.out",  16'(out4),  16'h0);
    check("reset.cur",  16'(cur4),  16'h0);
    check("reset.tick", 16'(tick4), 16'h0);
    rst = 1'b0;

    // Manual select: two cycles from sel to out.
    data_in = 16'hA5C3; sel = 2'd2;
    cyc(1);
    check("manual.cur2", 16'(cur4), 16'h2);
    cyc(1);
    check("manual.out5", 16'(out4), 16'h5);
    check("manual3.out5", 16'(out3), 16'h5);
    sel = 2'd3;
    cyc(2);
    check("manual.outA", 16'(out4), 16'hA);
    check("manual3.sel_oob", 16'(cur3), 16'h2);

    // Scan tour with wrap, channel 2 masked out.
    sel = 2'd0;
    cyc(1);
    mode = 1'b1; mask = 4'b1011;
    tour[0] = 2'd1; tour[1] = 2'd3; tour[2] = 2'd0; tour[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      cyc(3);
      check("scan.cur",  16'(cur4),  16'(tour[i]));
      check("scan.tick", 16'(tick4), 16'h1);
    end

    // Empty mask parks the tour; single-channel mask self-advances.
    mask = 4'b0000;
    cyc(20);
    check("mask0.cur", 16'(cur4), 16'h1);
    mask = 4'b0100;
    cyc(1);
    check("mask1.cur",  16'(cur4),  16'h2);
    check("mask1.tick", 16'(tick4), 16'h1);
    cyc(3);
    check("mask1.again", 16'(tick4), 16'h1);
    cyc(1);

    // Hold with counter at 1 while data changes.
    hold = 1'b1;
    saved_out = out4; saved_cur = cur4;
    for (int i = 0; i < 10; i++) begin
      data_in = 16'($urandom);
      cyc(1);
    end
    check("hold.out", 16'(out4), 16'(saved_out));
    check("hold.cur", 16'(cur4), 16'(saved_cur));
    hold = 1'b0;
    cyc(1);
    check("unhold.tick_early", 16'(tick4), 16'h0);
    cyc(1);
    check("unhold.tick", 16'(tick4), 16'h1);

    // Mode switch mid-dwell on channel 1.
    mask = 4'b0010;
    cyc(3);
    check("tour.ch1", 16'(cur4), 16'h1);
    cyc(1);
    mode = 1'b0; sel = 2'd0;
    cyc(1);
    check("switch.cur",  16'(cur4),  16'h0);
    check("switch.tick", 16'(tick4), 16'h0);
    mode = 1'b1;
    cyc(2);
    check("rescan.early", 16'(tick4), 16'h0);
    cyc(1);
    check("rescan.tick", 16'(tick4), 16'h1);
    check("rescan.cur",  16'(cur4),  16'h1);

    // Synchronous reset mid-dwell.
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check("rst.out",  16'(out4), 16'h0);
    check("rst.cur",  16'(cur4), 16'h0);
    check("rst3.out", 16'(out3), 16'h0);
    check("rst3.cur", 16'(cur3), 16'h0);
    rst = 1'b0;

    // Randomised traffic, compared cycle by cycle through the scoreboard.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      hold    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom);
      if ($urandom_range(0, 11) == 0) mask = 4'($urandom);
      data_in = 16'($urandom);
      cyc(1);
    end
    rst = 1'b0; hold = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
